// File: rtl/serial_rx_8x.sv
// serial_rx_8x -- 8N1 UART receiver for the serial console.
//
// Consumes the 8x-baud pulse train from the timing block, synchronises the raw
// RX pin, takes a 3-sample majority vote per bit (ticks 3,4,5 of 0..7) and
// frames 8N1 characters. Completed bytes are offered on a valid/ready port.
//
// Build option: define FPGA_ROBOTS_SERIAL_RX_FIFO_EN to buffer completed bytes
// in a 2^FIFO_DEPTH_LOG2-entry FIFO; otherwise a single holding register is used
// and FIFO_DEPTH_LOG2 has no effect.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   baud8      single-cycle pulse, 8 per bit time; all sampling/state advance
//   rxd        raw serial line, idle high, asynchronous to clk
//   rx_data    received byte, meaningful only while rx_valid=1
//   rx_valid   byte available
//   rx_ready   consumer accepts the byte
//   frm_err    one-cycle pulse: stop bit sampled low
//   ovr_err    one-cycle pulse: completed byte dropped (no room)
//   state_dbg  receiver state: 0=IDLE 1=START 2=DATA 3=STOP 4=BRK
//
// Handshake: a byte transfers on every clk edge where rx_valid && rx_ready.
// While rx_valid=1 and not accepted, rx_data holds steady. rx_valid drops the
// cycle after a transfer unless another byte loads in that same cycle.
module serial_rx_8x #(
  parameter int SYNC_STAGES     = 2,
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       baud8,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frm_err,
  output logic       ovr_err,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxd_s;
  logic [2:0]             sub_q, sub_d;
  logic [2:0]             bit_q, bit_d;
  logic [7:0]             shreg_q, shreg_d;
  logic [1:0]             smp_q, smp_d;   // samples taken at sub=3 and sub=4
  logic                   vote;
  logic                   byte_done;
  logic                   frm_hit;
  logic                   frm_q;
  logic                   ovr_q;

  // Synchroniser resets to idle-high so a reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '1;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
  end

  assign rxd_s = sync_q[SYNC_STAGES-1];

  // Third sample is the live value at sub=5, so the decision lands on that tick.
  assign vote = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxd_s) | (smp_q[1] & rxd_s);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sub_q   <= 3'd0;
      bit_q   <= 3'd0;
      shreg_q <= 8'd0;
      smp_q   <= 2'b11;
      frm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sub_q   <= sub_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      smp_q   <= smp_d;
      frm_q   <= frm_hit;
    end
  end

  always_comb begin
    state_d   = state_q;
    sub_d     = sub_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    smp_d     = smp_q;
    byte_done = 1'b0;
    frm_hit   = 1'b0;
    if (baud8) begin
      sub_d = sub_q + 3'd1;
      if (sub_q == 3'd3) smp_d[0] = rxd_s;
      if (sub_q == 3'd4) smp_d[1] = rxd_s;
      case (state_q)
        IDLE: begin
          // The tick that first sees the line low is tick 0 of the start bit.
          sub_d = 3'd0;
          if (!rxd_s) begin
            state_d = START;
            sub_d   = 3'd1;
          end
        end
        START: begin
          if (sub_q == 3'd5 && vote) begin
            state_d = IDLE;
          end else if (sub_q == 3'd7) begin
            state_d = DATA;
            bit_d   = 3'd0;
          end
        end
        DATA: begin
          if (sub_q == 3'd5) shreg_d = {vote, shreg_q[7:1]};
          if (sub_q == 3'd7) begin
            if (bit_q == 3'd7) state_d = STOP;
            else               bit_d   = bit_q + 3'd1;
          end
        end
        STOP: begin
          // Leave at the decision tick so an early next start bit is caught.
          if (sub_q == 3'd5) begin
            if (vote) begin
              state_d   = IDLE;
              byte_done = 1'b1;
            end else begin
              state_d = BRK;
              frm_hit = 1'b1;
            end
          end
        end
        BRK: begin
          if (rxd_s) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef FPGA_ROBOTS_SERIAL_RX_FIFO_EN
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;

  logic [7:0]               mem_q [DEPTH];
  logic [FIFO_DEPTH_LOG2:0] wr_q, rd_q;   // extra MSB distinguishes full from empty
  logic                     empty, full, pop, push;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[FIFO_DEPTH_LOG2] != rd_q[FIFO_DEPTH_LOG2]) &&
                 (wr_q[FIFO_DEPTH_LOG2-1:0] == rd_q[FIFO_DEPTH_LOG2-1:0]);
  assign pop   = !empty && rx_ready;
  assign push  = byte_done && (!full || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'd0;
      wr_q  <= '0;
      rd_q  <= '0;
      ovr_q <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_q[FIFO_DEPTH_LOG2-1:0]] <= shreg_q;
        wr_q <= wr_q + {{FIFO_DEPTH_LOG2{1'b0}}, 1'b1};
      end
      if (pop) rd_q <= rd_q + {{FIFO_DEPTH_LOG2{1'b0}}, 1'b1};
      ovr_q <= byte_done && full && !pop;
    end
  end

  assign rx_valid = !empty;
  assign rx_data  = mem_q[rd_q[FIFO_DEPTH_LOG2-1:0]];
`else
  logic [7:0] data_q;
  logic       valid_q;

  // A completion alongside a transfer reloads the register, so no overrun then.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= 8'd0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      if (byte_done) begin
        if (!valid_q || rx_ready) begin
          data_q  <= shreg_q;
          valid_q <= 1'b1;
        end else begin
          ovr_q <= 1'b1;
        end
      end else if (valid_q && rx_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign rx_valid = valid_q;
  assign rx_data  = data_q;
`endif

  assign frm_err   = frm_q;
  assign ovr_err   = ovr_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_serial_rx_8x.sv
// Bench for serial_rx_8x. Drives the line one baud8 slot at a time (DIV clocks
// per slot, tick on the last clock) and keeps a byte-level model of the output
// buffer (exp_q, capacity 1 or the FIFO depth) fed by frame-completion events.
module tb_serial_rx_8x;

  localparam int DIV = 4;
`ifdef FPGA_ROBOTS_SERIAL_RX_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif
  localparam logic [2:0] ST_IDLE = 3'd0;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic       baud8;
  logic       rxd;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frm_err;
  logic       ovr_err;
  logic [2:0] state_dbg;

  always #5 clk = ~clk;

  serial_rx_8x dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .baud8    (baud8),
    .rxd      (rxd),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frm_err  (frm_err),
    .ovr_err  (ovr_err),
    .state_dbg(state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_q[$];
  logic       m_frm = 1'b0;
  logic       m_ovr = 1'b0;
  int         ready_mode = 1;   // 0: never ready, 1: always, 2: random
  int         n_pop = 0;
  int         n_frm = 0;
  int         n_ovr = 0;
  logic [7:0] last_pop = 8'd0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic bit_val(input logic [7:0] b, input int bi);
    if (bi == 0) return 1'b0;
    if (bi == 9) return 1'b1;
    return b[bi-1];
  endfunction

  // ---------------- driver tasks ----------------
  // One clock: check outputs against the model, drive inputs for the next edge,
  // then advance the model for that edge. ev: 1 = byte completes, 2 = framing error.
  task automatic cycle(input logic b8, input int ev, input logic [7:0] b);
    @(negedge clk);
    check_val("valid", 32'(rx_valid), 32'(exp_q.size() > 0));
    if (exp_q.size() > 0) check_val("data", 32'(rx_data), 32'(exp_q[0]));
    check_val("frm_err", 32'(frm_err), 32'(m_frm));
    check_val("ovr_err", 32'(ovr_err), 32'(m_ovr));
    if (frm_err) n_frm++;
    if (ovr_err) n_ovr++;
    baud8 = b8;
    case (ready_mode)
      0:       rx_ready = 1'b0;
      1:       rx_ready = 1'b1;
      default: rx_ready = ($urandom_range(0, 3) != 0);
    endcase
    if (rx_valid && rx_ready) begin
      n_pop++;
      last_pop = rx_data;
    end
    if (exp_q.size() > 0 && rx_ready) void'(exp_q.pop_front());
    m_frm = b8 && (ev == 2);
    m_ovr = 1'b0;
    if (b8 && ev == 1) begin
      if (exp_q.size() < CAP) exp_q.push_back(b);
      else                    m_ovr = 1'b1;
    end
  endtask

  task automatic send_slot(input logic v, input int ev, input logic [7:0] b);
    rxd = v;
    for (int i = 0; i < DIV; i++) cycle(i == DIV - 1, ev, b);
  endtask

  task automatic idle_slots(input int n);
    for (int i = 0; i < n; i++) send_slot(1'b1, 0, 8'd0);
  endtask

  // gbit/gslot force one inverted sample; rnd_glitch adds at most one inverted
  // voting sample per bit; brk_bits>0 holds the stop bit low that many bit times.
  task automatic send_frame(input logic [7:0] b, input bit rnd_glitch,
                            input int gbit, input int gslot, input int brk_bits);
    int   gs;
    int   ev;
    logic v;
    for (int bi = 0; bi < 10; bi++) begin
      gs = -1;
      if (bi == gbit) gs = gslot;
      else if (rnd_glitch && bi < 9 && $urandom_range(0, 1) == 1) gs = int'($urandom_range(3, 5));
      for (int s = 0; s < 8; s++) begin
        v  = bit_val(b, bi);
        ev = 0;
        if (s == gs) v = ~v;
        if (bi == 9) begin
          if (brk_bits > 0) begin
            v = 1'b0;
            if (s == 5) ev = 2;
          end else if (s == 5) begin
            ev = 1;
          end
        end
        send_slot(v, ev, b);
      end
    end
    if (brk_bits > 0) begin
      for (int k = 0; k < (brk_bits - 1) * 8; k++) send_slot(1'b0, 0, b);
      idle_slots(8);
    end
  endtask

  task automatic do_reset(input int ncyc);
    @(negedge clk);
    rst_n = 1'b0;
    rxd   = 1'b1;
    baud8 = 1'b0;
    exp_q.delete();
    m_frm = 1'b0;
    m_ovr = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      #1;
      check_val("rst_valid", 32'(rx_valid), 32'd0);
      check_val("rst_data", 32'(rx_data), 32'd0);
      check_val("rst_frm", 32'(frm_err), 32'd0);
      check_val("rst_ovr", 32'(ovr_err), 32'd0);
      @(negedge clk);
    end
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  int p0;
  int f0;
  int o0;

  initial begin
    rst_n    = 1'b0;
    rxd      = 1'b1;
    baud8    = 1'b0;
    rx_ready = 1'b0;
    do_reset(4);
    check_val("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    idle_slots(16);

    // 0xA5, always ready
    ready_mode = 1;
    p0 = n_pop; f0 = n_frm; o0 = n_ovr;
    send_frame(8'hA5, 1'b0, -1, 0, 0);
    idle_slots(4);
    check_val("a5_pops", 32'(n_pop - p0), 32'd1);
    check_val("a5_data", 32'(last_pop), 32'hA5);
    check_val("a5_frm", 32'(n_frm - f0), 32'd0);
    check_val("a5_ovr", 32'(n_ovr - o0), 32'd0);

    // false start: low for two ticks only
    p0 = n_pop;
    send_slot(1'b0, 0, 8'd0);
    send_slot(1'b0, 0, 8'd0);
    @(posedge clk); #1;
    check_val("fs_busy", 32'(state_dbg != ST_IDLE), 32'd1);
    for (int i = 0; i < 4; i++) send_slot(1'b1, 0, 8'd0);
    @(posedge clk); #1;
    check_val("fs_idle", 32'(state_dbg), 32'(ST_IDLE));
    idle_slots(16);
    check_val("fs_pops", 32'(n_pop - p0), 32'd0);

    // 0x3C with data bit 2 inverted at sub=4
    p0 = n_pop;
    send_frame(8'h3C, 1'b0, 3, 4, 0);
    idle_slots(4);
    check_val("glitch_pops", 32'(n_pop - p0), 32'd1);
    check_val("glitch_data", 32'(last_pop), 32'h3C);

    // 0x55 with stop held low 20 bit times, then 0x12
    p0 = n_pop; f0 = n_frm;
    send_frame(8'h55, 1'b0, -1, 0, 20);
    send_frame(8'h12, 1'b0, -1, 0, 0);
    idle_slots(4);
    check_val("brk_frm", 32'(n_frm - f0), 32'd1);
    check_val("brk_pops", 32'(n_pop - p0), 32'd1);
    check_val("brk_data", 32'(last_pop), 32'h12);

    // overrun with consumer stalled: 0x11 then 0x22
    ready_mode = 0;
    o0 = n_ovr;
    send_frame(8'h11, 1'b0, -1, 0, 0);
    send_frame(8'h22, 1'b0, -1, 0, 0);
    idle_slots(2);
    check_val("ovr2_head", 32'(rx_data), 32'h11);
    check_val("ovr2_count", 32'(n_ovr - o0), (CAP == 1) ? 32'd1 : 32'd0);
    ready_mode = 1;
    idle_slots(4);

    // five back-to-back frames into a stalled consumer
    ready_mode = 0;
    o0 = n_ovr;
    for (int k = 1; k <= 5; k++) send_frame(8'(k), 1'b0, -1, 0, 0);
    idle_slots(2);
    check_val("ovr5_head", 32'(rx_data), 32'h01);
    check_val("ovr5_count", 32'(n_ovr - o0), 32'(5 - CAP));
    p0 = n_pop;
    ready_mode = 1;
    idle_slots(4);
    check_val("ovr5_pops", 32'(n_pop - p0), 32'(CAP));
    check_val("ovr5_last", 32'(last_pop), 32'(CAP));

    // reset in the middle of 0x77's data bits, then 0x42
    p0 = n_pop;
    for (int bi = 0; bi < 4; bi++)
      for (int s = 0; s < 8; s++) send_slot(bit_val(8'h77, bi), 0, 8'd0);
    for (int s = 0; s < 3; s++) send_slot(bit_val(8'h77, 4), 0, 8'd0);
    do_reset(3);
    idle_slots(16);
    send_frame(8'h42, 1'b0, -1, 0, 0);
    idle_slots(4);
    check_val("mrst_pops", 32'(n_pop - p0), 32'd1);
    check_val("mrst_data", 32'(last_pop), 32'h42);

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      ready_mode = int'($urandom_range(0, 2));
      send_frame(8'($urandom_range(0, 255)), 1'b1, -1, 0,
                 ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0);
      idle_slots(int'($urandom_range(0, 3)));
    end
    ready_mode = 1;
    idle_slots(16);
    check_val("end_empty", 32'(rx_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
